// File: rtl/return_stack_predictor_pkg.sv
// Shared definitions for the return-address stack predictor:
// link-register numbers and the stack operation encoding.
package return_stack_predictor_pkg;

   localparam logic [4:0] LINK_REG_X1 = 5'd1;
   localparam logic [4:0] LINK_REG_X5 = 5'd5;

   typedef enum logic [1:0] {
      OP_NONE     = 2'd0,
      OP_PUSH     = 2'd1,
      OP_POP      = 2'd2,
      OP_POP_PUSH = 2'd3
   } ras_op_e;

   function automatic logic is_link_reg(input logic [4:0] reg_idx);
      return (reg_idx == LINK_REG_X1) || (reg_idx == LINK_REG_X5);
   endfunction

endpackage

// File: rtl/return_stack_predictor_decode.sv
// Combinational decode of a JAL/JALR into a return-stack operation,
// following the RISC-V link-register hint rules.
module return_stack_predictor_decode
   import return_stack_predictor_pkg::*;
(
   input  logic [4:0] rd_in,
   input  logic [4:0] rs1_in,
   input  logic       jump_signal_in,
   input  logic       jalr_inst_signal_in,
   output ras_op_e    op_out
);

   logic rd_link;
   logic rs1_link;

   assign rd_link  = is_link_reg(rd_in);
   assign rs1_link = is_link_reg(rs1_in);

   always_comb begin
      op_out = OP_NONE;
      if (jump_signal_in) begin
         if (!jalr_inst_signal_in) begin
            if (rd_link) op_out = OP_PUSH;
         end else begin
            unique case ({rd_link, rs1_link})
               2'b10:   op_out = OP_PUSH;
               2'b01:   op_out = OP_POP;
               // Same link register on both sides is a plain call, not a coroutine swap
               2'b11:   op_out = (rd_in == rs1_in) ? OP_PUSH : OP_POP_PUSH;
               default: op_out = OP_NONE;
            endcase
         end
      end
   end

endmodule

// File: rtl/return_stack_predictor.sv
// Circular return-address stack with overflow wrap, underflow detection
// and a one-deep speculation checkpoint (tos, count, top entry).
module return_stack_predictor
   import return_stack_predictor_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [4:0]               rd_in,
   input  logic [4:0]               rs1_in,
   input  logic                     jump_signal_in,
   input  logic                     jalr_inst_signal_in,
   input  logic [XLEN-1:0]          return_address_in,
   input  logic                     stall_signal_in,
   input  logic                     flush_signal_in,
   input  logic                     checkpoint_signal_in,
   input  logic                     restore_signal_in,
   output logic [XLEN-1:0]          return_address_out,
   output logic                     return_valid_out,
   output logic [$clog2(DEPTH):0]   count_out,
   output logic                     overflow_out,
   output logic                     underflow_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   ras_op_e op;

   logic [XLEN-1:0]  entries [DEPTH];
   logic [PTR_W-1:0] tos;
   logic [CNT_W-1:0] count;

   logic [PTR_W-1:0] snap_tos;
   logic [CNT_W-1:0] snap_count;
   logic [XLEN-1:0]  snap_value;

   logic [PTR_W-1:0] tos_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             overflow_nxt;
   logic             underflow_nxt;
   logic             capture;
   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [XLEN-1:0]  wr_data;
   logic [XLEN-1:0]  top_entry;
   logic             stack_empty;

   return_stack_predictor_decode u_decode (
      .rd_in               (rd_in),
      .rs1_in              (rs1_in),
      .jump_signal_in      (jump_signal_in),
      .jalr_inst_signal_in (jalr_inst_signal_in),
      .op_out              (op)
   );

   assign top_entry          = entries[tos];
   assign stack_empty        = (count == '0);
   assign return_address_out = stack_empty ? '0 : top_entry;
   assign return_valid_out   = ((op == OP_POP) || (op == OP_POP_PUSH)) && !stack_empty;
   assign count_out          = count;

   // Priority: reset > restore > (stall | flush) > decoded op
   always_comb begin
      tos_nxt       = tos;
      count_nxt     = count;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
      capture       = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = tos;
      wr_data       = return_address_in;
      if (rst_in) begin
         wr_en = 1'b0;
      end else if (restore_signal_in) begin
         tos_nxt   = snap_tos;
         count_nxt = snap_count;
         wr_en     = 1'b1;
         wr_addr   = snap_tos;
         wr_data   = snap_value;
      end else if (!stall_signal_in && !flush_signal_in) begin
         capture = checkpoint_signal_in;
         unique case (op)
            OP_PUSH: begin
               tos_nxt      = tos + PTR_W'(1);
               wr_en        = 1'b1;
               wr_addr      = tos + PTR_W'(1);
               overflow_nxt = (count == FULL_COUNT);
               if (count != FULL_COUNT) count_nxt = count + CNT_W'(1);
            end
            OP_POP: begin
               if (stack_empty) begin
                  underflow_nxt = 1'b1;
               end else begin
                  tos_nxt   = tos - PTR_W'(1);
                  count_nxt = count - CNT_W'(1);
               end
            end
            OP_POP_PUSH: begin
               wr_en   = 1'b1;
               wr_addr = tos;
               if (stack_empty) count_nxt = CNT_W'(1);
            end
            default: begin
               tos_nxt = tos;
            end
         endcase
      end
   end

   // Entry storage is deliberately left unreset; count gates its visibility
   always_ff @(posedge clk_in) begin
      if (wr_en) entries[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tos           <= '0;
         count         <= '0;
         snap_tos      <= '0;
         snap_count    <= '0;
         snap_value    <= '0;
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else begin
         tos           <= tos_nxt;
         count         <= count_nxt;
         overflow_out  <= overflow_nxt;
         underflow_out <= underflow_nxt;
         if (capture) begin
            snap_tos   <= tos;
            snap_count <= count;
            snap_value <= top_entry;
         end
      end
   end

endmodule

// File: tb/tb_return_stack_predictor.sv
// Directed bench for return_stack_predictor at DEPTH=4, XLEN=64 with
// hand-computed expectations checked by immediate assertions.
module tb_return_stack_predictor;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [4:0]  rd_in;
   logic [4:0]  rs1_in;
   logic        jump_signal_in;
   logic        jalr_inst_signal_in;
   logic [63:0] return_address_in;
   logic        stall_signal_in;
   logic        flush_signal_in;
   logic        checkpoint_signal_in;
   logic        restore_signal_in;
   logic [63:0] return_address_out;
   logic        return_valid_out;
   logic [2:0]  count_out;
   logic        overflow_out;
   logic        underflow_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

   return_stack_predictor #(.XLEN(64), .DEPTH(4)) dut (
      .clk_in               (clk_in),
      .rst_in               (rst_in),
      .rd_in                (rd_in),
      .rs1_in               (rs1_in),
      .jump_signal_in       (jump_signal_in),
      .jalr_inst_signal_in  (jalr_inst_signal_in),
      .return_address_in    (return_address_in),
      .stall_signal_in      (stall_signal_in),
      .flush_signal_in      (flush_signal_in),
      .checkpoint_signal_in (checkpoint_signal_in),
      .restore_signal_in    (restore_signal_in),
      .return_address_out   (return_address_out),
      .return_valid_out     (return_valid_out),
      .count_out            (count_out),
      .overflow_out         (overflow_out),
      .underflow_out        (underflow_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rd_in                = '0;
      rs1_in               = '0;
      jump_signal_in       = 1'b0;
      jalr_inst_signal_in  = 1'b0;
      return_address_in    = '0;
      stall_signal_in      = 1'b0;
      flush_signal_in      = 1'b0;
      checkpoint_signal_in = 1'b0;
      restore_signal_in    = 1'b0;
   endtask

   task automatic jal(input logic [4:0] rd, input logic [63:0] addr);
      idle();
      jump_signal_in    = 1'b1;
      rd_in             = rd;
      return_address_in = addr;
   endtask

   task automatic jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [63:0] addr);
      idle();
      jump_signal_in      = 1'b1;
      jalr_inst_signal_in = 1'b1;
      rd_in               = rd;
      rs1_in              = rs1;
      return_address_in   = addr;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      logic [63:0] push_vals [5];
      logic [63:0] pop_vals [4];
      push_vals = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
      pop_vals  = '{64'h50, 64'h40, 64'h30, 64'h20};

      idle();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      check("reset_count", 64'(count_out), 64'd0);
      check("reset_addr", return_address_out, 64'h0);
      check("reset_valid", 64'(return_valid_out), 64'd0);
      check("reset_ovf", 64'(overflow_out), 64'd0);
      check("reset_unf", 64'(underflow_out), 64'd0);

      // Call then return
      jal(5'd1, 64'h100);
      tick();
      check("call_count", 64'(count_out), 64'd1);
      jalr(5'd0, 5'd1, 64'h0);
      #1;
      check("ret_addr", return_address_out, 64'h100);
      check("ret_valid", 64'(return_valid_out), 64'd1);
      tick();
      check("ret_count", 64'(count_out), 64'd0);

      // Five pushes into a four-deep stack
      for (int i = 0; i < 5; i++) begin
         jal(5'd5, push_vals[i]);
         tick();
         check($sformatf("push%0d_ovf", i), 64'(overflow_out), (i == 4) ? 64'd1 : 64'd0);
      end
      check("full_count", 64'(count_out), 64'd4);
      check("full_top", return_address_out, 64'h50);
      idle();
      tick();
      check("ovf_single_pulse", 64'(overflow_out), 64'd0);
      for (int i = 0; i < 4; i++) begin
         jalr(5'd0, 5'd5, 64'h0);
         #1;
         check($sformatf("pop%0d_addr", i), return_address_out, pop_vals[i]);
         check($sformatf("pop%0d_valid", i), 64'(return_valid_out), 64'd1);
         tick();
         check($sformatf("pop%0d_unf", i), 64'(underflow_out), 64'd0);
      end
      check("drained_count", 64'(count_out), 64'd0);
      jalr(5'd0, 5'd5, 64'h0);
      #1;
      check("empty_pop_addr", return_address_out, 64'h0);
      check("empty_pop_valid", 64'(return_valid_out), 64'd0);
      tick();
      check("empty_pop_unf", 64'(underflow_out), 64'd1);
      check("empty_pop_count", 64'(count_out), 64'd0);
      idle();
      tick();
      check("unf_single_pulse", 64'(underflow_out), 64'd0);

      // Coroutine swap
      jal(5'd1, 64'hA0);
      tick();
      jalr(5'd5, 5'd1, 64'hB0);
      #1;
      check("swap_addr", return_address_out, 64'hA0);
      check("swap_valid", 64'(return_valid_out), 64'd1);
      tick();
      check("swap_count", 64'(count_out), 64'd1);
      check("swap_top", return_address_out, 64'hB0);
      check("swap_unf", 64'(underflow_out), 64'd0);
      jalr(5'd0, 5'd1, 64'h0);
      tick();
      check("swap_drain_count", 64'(count_out), 64'd0);

      // Checkpoint and restore repairs an overwritten top entry
      jal(5'd1, 64'h1000);
      tick();
      idle();
      checkpoint_signal_in = 1'b1;
      tick();
      jal(5'd1, 64'h2000);
      tick();
      jalr(5'd0, 5'd1, 64'h0);
      tick();
      jalr(5'd0, 5'd1, 64'h0);
      tick();
      jal(5'd1, 64'h3000);
      tick();
      check("pre_restore_top", return_address_out, 64'h3000);
      idle();
      restore_signal_in = 1'b1;
      tick();
      check("restore_count", 64'(count_out), 64'd1);
      check("restore_top", return_address_out, 64'h1000);

      // Stall and flush suppress pushes; restore ignores stall
      jal(5'd1, 64'h4444);
      stall_signal_in = 1'b1;
      tick();
      check("stall_count", 64'(count_out), 64'd1);
      check("stall_top", return_address_out, 64'h1000);
      jal(5'd1, 64'h5555);
      flush_signal_in = 1'b1;
      tick();
      check("flush_count", 64'(count_out), 64'd1);
      check("flush_top", return_address_out, 64'h1000);
      jal(5'd5, 64'h5000);
      tick();
      check("push_after_flush", 64'(count_out), 64'd2);
      idle();
      stall_signal_in   = 1'b1;
      restore_signal_in = 1'b1;
      tick();
      check("stall_restore_count", 64'(count_out), 64'd1);
      check("stall_restore_top", return_address_out, 64'h1000);

      // Remaining decode cases
      jalr(5'd1, 5'd1, 64'h6000);
      #1;
      check("same_link_valid", 64'(return_valid_out), 64'd0);
      tick();
      check("same_link_count", 64'(count_out), 64'd2);
      check("same_link_top", return_address_out, 64'h6000);
      jal(5'd2, 64'h7777);
      tick();
      check("jal_nolink_count", 64'(count_out), 64'd2);
      jalr(5'd3, 5'd4, 64'h8888);
      #1;
      check("jalr_nolink_valid", 64'(return_valid_out), 64'd0);
      tick();
      check("jalr_nolink_count", 64'(count_out), 64'd2);

      // Reset dominates push and restore
      idle();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      jal(5'd1, 64'h7000);
      tick();
      jal(5'd1, 64'h7100);
      tick();
      jal(5'd1, 64'h7200);
      tick();
      check("three_push_count", 64'(count_out), 64'd3);
      jal(5'd1, 64'h7300);
      restore_signal_in = 1'b1;
      rst_in            = 1'b1;
      tick();
      check("rst_prio_count", 64'(count_out), 64'd0);
      check("rst_prio_addr", return_address_out, 64'h0);
      check("rst_prio_ovf", 64'(overflow_out), 64'd0);
      check("rst_prio_unf", 64'(underflow_out), 64'd0);
      rst_in = 1'b0;
      idle();
      tick();
      check("post_rst_count", 64'(count_out), 64'd0);
      check("post_rst_valid", 64'(return_valid_out), 64'd0);
      restore_signal_in = 1'b1;
      tick();
      check("restore_no_snap_count", 64'(count_out), 64'd0);
      check("restore_no_snap_addr", return_address_out, 64'h0);
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
